// File: rtl/psum_accum_relu.sv
// Per-lane partial-sum accumulator for multi-chunk pixels, followed by rounding shift,
// optional ReLU and 16-bit saturation, with a one-word valid/ready output register.
module psum_accum_relu #(
    parameter int M     = 8,
    parameter int ACC_W = 24,
    parameter int CW    = 6,
    parameter int SHIFT = 0,
    parameter int RELU  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [CW-1:0]     cfg_chunks,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M*16-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M*16-1:0]   out_data,
    output logic              busy
);

    localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'((1 << SHIFT) >> 1);
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-32768);

    logic [CW-1:0]           r_chunk_cnt;
    logic [CW-1:0]           r_n_l;
    logic signed [ACC_W-1:0] r_acc [M];
    logic                    r_out_valid;
    logic [M*16-1:0]         r_out_data;

    logic                    w_first;
    logic [CW-1:0]           w_n_eff;
    logic                    w_is_last;
    logic                    w_accept;
    logic signed [ACC_W-1:0] w_sum [M];
    logic [M*16-1:0]         w_post;

    function automatic logic signed [ACC_W-1:0] sext(input logic [15:0] d);
        return {{(ACC_W-16){d[15]}}, d};
    endfunction

    // Round half up, shift, optional ReLU, then clamp to the signed 16-bit range.
    function automatic logic [15:0] post(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W:0] t;
        t = (ACC_W+1)'(x);
        t = t + RND;
        t = t >>> SHIFT;
        if (RELU != 0 && t[ACC_W])
            t = '0;
        if (t > SAT_HI)
            return 16'h7FFF;
        else if (t < SAT_LO)
            return 16'h8000;
        else
            return t[15:0];
    endfunction

    always_comb begin
        w_first = (r_chunk_cnt == '0);
        w_n_eff = r_n_l;
        if (w_first)
            w_n_eff = (cfg_chunks == '0) ? CW'(1) : cfg_chunks;
        w_is_last = (r_chunk_cnt == w_n_eff - CW'(1));
        // Only a finishing chunk needs the output register, so only it can stall.
        in_ready  = !(w_is_last && r_out_valid && !out_ready);
        w_accept  = in_valid && in_ready;
        w_post    = '0;
        for (int i = 0; i < M; i++) begin
            w_sum[i] = (w_first ? '0 : r_acc[i]) + sext(in_data[16*i +: 16]);
            w_post[16*i +: 16] = post(w_sum[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chunk_cnt <= '0;
            r_n_l       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < M; i++)
                r_acc[i] <= '0;
        end else begin
            if (flush) begin
                r_chunk_cnt <= '0;
                for (int i = 0; i < M; i++)
                    r_acc[i] <= '0;
            end else if (w_accept) begin
                for (int i = 0; i < M; i++)
                    r_acc[i] <= w_sum[i];
                if (w_first)
                    r_n_l <= w_n_eff;
                r_chunk_cnt <= w_is_last ? '0 : r_chunk_cnt + CW'(1);
                if (w_is_last)
                    r_out_data <= w_post;
            end
            // A held word survives flush; only a consumer handshake retires it.
            if (!flush && w_accept && w_is_last)
                r_out_valid <= 1'b1;
            else if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_chunk_cnt != '0);

endmodule
